pipe_core: RTL and testbench

Two-stage (fetch / execute) pipelined successor to the single-cycle `top_level` core. It is parametrised in data width and PC width. It fetches 9-bit instructions from an external instruction ROM port and executes them against an internal register file. It adds a variable-latency data-memory handshake with pipeline stall, a branch flush, a sticky halt and a retired-instruction counter. It sits at the top of the design in place of `top_level` and drives `done` to the bench.

---
 rtl/pipe_core.sv | 177 +++++++++++++++++
 tb/tb_pipe_core.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_core.sv
// pipe_core: two-stage fetch/execute core with an 8-entry register file, a
// stalling data-memory handshake, branch flush, sticky halt and retire counter.
module pipe_core #(
    parameter int W  = 8,
    parameter int D  = 12,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    output logic [D-1:0]  imem_addr,
    input  logic [8:0]    imem_data,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [W-1:0]  dmem_addr,
    output logic [W-1:0]  dmem_wdata,
    input  logic [W-1:0]  dmem_rdata,
    input  logic          dmem_ready,
    output logic          done,
    output logic [CW-1:0] retired
);
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_LDI = 3'd4,
        OP_LD  = 3'd5,
        OP_ST  = 3'd6,
        OP_BR  = 3'd7
    } op_e;

    localparam logic [8:0] HALT_INSN = 9'h1FF;

    logic [D-1:0] pc;
    logic [8:0]   ir;
    logic         ir_valid;
    logic [W-1:0] regs [8];
    logic         flag_z;
    logic         flag_n;
    logic         flag_c;

    op_e          op;
    logic [2:0]   rd;
    logic [2:0]   rs;
    logic [W-1:0] rd_val;
    logic [W-1:0] rs_val;
    logic [W-1:0] imm;
    logic         is_alu;

    logic         ex_valid;
    logic         ex_halt;
    logic         ex_mem;
    logic         ex_store;
    logic         stall;
    logic         ex_fire;
    logic         br_cond;
    logic         br_taken;
    logic [D-1:0] br_target;

    logic [W:0]   alu_sum;
    logic [W-1:0] alu_res;
    logic         alu_c;

    assign op     = op_e'(ir[8:6]);
    assign rd     = ir[5:3];
    assign rs     = ir[2:0];
    assign rd_val = regs[rd];
    assign rs_val = regs[rs];
    assign imm    = {{(W-3){ir[2]}}, ir[2:0]};
    assign is_alu = ~ir[8];

    // HALT shares the BR opcode, so it is decoded on the full word first.
    assign ex_valid = ir_valid && !done;
    assign ex_halt  = ex_valid && (ir == HALT_INSN);
    assign ex_mem   = ex_valid && (op == OP_LD || op == OP_ST);
    assign ex_store = ex_mem && (op == OP_ST);
    assign stall    = ex_mem && !dmem_ready;
    assign ex_fire  = ex_valid && !ex_halt && !stall;
    assign br_taken = ex_fire && (op == OP_BR) && br_cond;

    // Data port: dmem_req is the valid; while it is high we/addr/wdata stay
    // stable, and the access completes on the first rising edge with
    // dmem_ready=1. dmem_ready without dmem_req has no effect.
    assign dmem_req   = ex_mem;
    assign dmem_we    = ex_store;
    assign dmem_addr  = ex_mem ? rs_val : '0;
    assign dmem_wdata = ex_store ? rd_val : '0;
    assign imem_addr  = pc;

    generate
        if (W >= D) begin : g_target_trunc
            assign br_target = rs_val[D-1:0];
        end else begin : g_target_zext
            assign br_target = {{(D-W){1'b0}}, rs_val};
        end
    endgenerate

    always_comb begin
        br_cond = 1'b0;
        case (rd)
            3'd0:    br_cond = 1'b1;
            3'd1:    br_cond = flag_z;
            3'd2:    br_cond = !flag_z;
            3'd3:    br_cond = flag_n;
            3'd4:    br_cond = flag_c;
            default: br_cond = 1'b0;
        endcase
    end

    // SUB carry is the inverse of the borrow out of the W+1 bit difference.
    always_comb begin
        alu_sum = '0;
        alu_res = '0;
        alu_c   = flag_c;
        case (op)
            OP_ADD: begin
                alu_sum = {1'b0, rd_val} + {1'b0, rs_val};
                alu_res = alu_sum[W-1:0];
                alu_c   = alu_sum[W];
            end
            OP_SUB: begin
                alu_sum = {1'b0, rd_val} - {1'b0, rs_val};
                alu_res = alu_sum[W-1:0];
                alu_c   = ~alu_sum[W];
            end
            OP_AND:  alu_res = rd_val & rs_val;
            OP_XOR:  alu_res = rd_val ^ rs_val;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= '0;
            ir       <= '0;
            ir_valid <= 1'b0;
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
            flag_c   <= 1'b0;
            done     <= 1'b0;
            retired  <= '0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (ex_halt) begin
                done <= 1'b1;
            end else if (!done && !stall) begin
                if (br_taken) begin
                    pc       <= br_target;
                    ir_valid <= 1'b0;
                end else begin
                    pc       <= pc + 1'b1;
                    ir       <= imem_data;
                    ir_valid <= 1'b1;
                end
            end

            if (ex_fire) begin
                if (retired != '1) begin
                    retired <= retired + 1'b1;
                end
                if (is_alu) begin
                    regs[rd] <= alu_res;
                    flag_z   <= (alu_res == '0);
                    flag_n   <= alu_res[W-1];
                    flag_c   <= alu_c;
                end else if (op == OP_LDI) begin
                    regs[rd] <= imm;
                end else if (op == OP_LD) begin
                    regs[rd] <= dmem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_core.sv
// Bench for pipe_core: directed programs plus random programs, all checked
// against an instruction-level model of the ISA and its cycle-cost rules.
module tb_pipe_core;
  localparam int W   = 8;
  localparam int D   = 12;
  localparam int CW  = 16;
  localparam int XW  = 16;
  localparam int XD  = 4;
  localparam int XCW = 3;
  localparam int TBL = 512;
  localparam logic [8:0] HALT = 9'h1FF;

  logic           clk;
  logic           reset;
  logic [D-1:0]   imem_addr;
  logic [8:0]     imem_data;
  logic           dmem_req;
  logic           dmem_we;
  logic [W-1:0]   dmem_addr;
  logic [W-1:0]   dmem_wdata;
  logic [W-1:0]   dmem_rdata;
  logic           dmem_ready;
  logic           done;
  logic [CW-1:0]  retired;

  logic [XD-1:0]  imem_addr_x;
  logic [8:0]     imem_data_x;
  logic           dmem_req_x;
  logic           dmem_we_x;
  logic [XW-1:0]  dmem_addr_x;
  logic [XW-1:0]  dmem_wdata_x;
  logic [XW-1:0]  dmem_rdata_x;
  logic           dmem_ready_x;
  logic           done_x;
  logic [XCW-1:0] retired_x;

  logic [8:0] rom   [0:(1<<D)-1];
  logic [8:0] rom_x [0:(1<<XD)-1];

  assign imem_data   = rom[imem_addr];
  assign imem_data_x = rom_x[imem_addr_x];

  pipe_core #(.W(W), .D(D), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .done(done), .retired(retired)
  );

  pipe_core #(.W(XW), .D(XD), .CW(XCW)) dut_x (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr_x), .imem_data(imem_data_x),
    .dmem_req(dmem_req_x), .dmem_we(dmem_we_x), .dmem_addr(dmem_addr_x),
    .dmem_wdata(dmem_wdata_x), .dmem_rdata(dmem_rdata_x), .dmem_ready(dmem_ready_x),
    .done(done_x), .retired(retired_x)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  int           wait_tbl  [TBL];
  logic [W-1:0] rdata_tbl [TBL];
  logic [2*W:0] exp_q [$];
  int           len_q [$];
  logic [D-1:0] trace_q [$];
  logic [2*W:0] last_txn;
  int           m_retired;
  int           m_extra;
  int           m_txn;
  logic         m_halted;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] enc(input int op, input int rd, input int rs);
    logic [8:0] v;
    v = {op[2:0], rd[2:0], rs[2:0]};
    return v;
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < (1 << D); i++) rom[i] = HALT;
  endtask

  task automatic clear_tables();
    for (int i = 0; i < TBL; i++) begin
      wait_tbl[i]  = 0;
      rdata_tbl[i] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b0;
    dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Instruction-level reference: walks the program, builds the expected
  // memory transactions, retire count and extra cycles (waits, taken branches).
  task automatic model_run();
    logic [W-1:0] r [8];
    logic         z, n, c, take;
    logic [D-1:0] pc, pc_next;
    logic [8:0]   ins;
    logic [W-1:0] ra, rb, res;
    logic [2:0]   rd, rs;
    int           sum, imm, txn;
    exp_q.delete();
    m_retired = 0;
    m_extra   = 0;
    m_halted  = 1'b0;
    txn       = 0;
    for (int i = 0; i < 8; i++) r[i] = '0;
    z = 1'b0; n = 1'b0; c = 1'b0; pc = '0; res = '0;
    for (int step = 0; step < 300; step++) begin
      ins = rom[pc];
      if (ins == HALT) begin
        m_halted = 1'b1;
        break;
      end
      rd = ins[5:3];
      rs = ins[2:0];
      ra = r[rd];
      rb = r[rs];
      pc_next = pc + 1'b1;
      case (ins[8:6])
        3'd0: begin sum = int'(ra) + int'(rb); c = (sum >= (1 << W)); res = sum[W-1:0]; end
        3'd1: begin sum = int'(ra) - int'(rb); c = (ra >= rb); res = sum[W-1:0]; end
        3'd2: res = ra & rb;
        3'd3: res = ra ^ rb;
        3'd4: begin
          imm = int'(ins[2:0]);
          if (imm > 3) imm -= 8;
          r[rd] = imm[W-1:0];
        end
        3'd5: begin
          exp_q.push_back({1'b0, rb, {W{1'b0}}});
          r[rd] = rdata_tbl[txn];
          m_extra += wait_tbl[txn];
          txn++;
        end
        3'd6: begin
          exp_q.push_back({1'b1, rb, ra});
          m_extra += wait_tbl[txn];
          txn++;
        end
        default: begin
          case (rd)
            3'd0: take = 1'b1;
            3'd1: take = z;
            3'd2: take = !z;
            3'd3: take = n;
            3'd4: take = c;
            default: take = 1'b0;
          endcase
          if (take) begin
            pc_next = {{(D-W){1'b0}}, rb};
            m_extra++;
          end
        end
      endcase
      if (ins[8] == 1'b0) begin
        r[rd] = res;
        z = (res == 0);
        n = (int'(res) >= (1 << (W-1)));
      end
      if (m_retired < (1 << CW) - 1) m_retired++;
      pc = pc_next;
    end
    m_txn = txn;
  endtask

  // Releases reset and runs until done, serving memory requests with the
  // wait/rdata tables and checking each transaction against exp_q.
  task automatic run_prog(input string tag, input int max_cyc);
    int           txn, wcnt, req_len, done_cyc;
    logic         in_txn;
    logic [2*W:0] got, cur;
    logic [D-1:0] pc_hold;
    trace_q.delete();
    len_q.delete();
    txn = 0; wcnt = 0; req_len = 0; in_txn = 1'b0; done_cyc = -1;
    cur = '0; pc_hold = '0;
    reset = 1'b1;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      trace_q.push_back(imem_addr);
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (in_txn) check({tag, " req_hold"}, dmem_req, 1'b1);
      if (dmem_req) begin
        got = {dmem_we, dmem_addr, dmem_we ? dmem_wdata : {W{1'b0}}};
        if (!in_txn) begin
          if (exp_q.size() == 0) check({tag, " req_count"}, txn + 1, m_txn);
          else check({tag, " txn"}, got, exp_q.pop_front());
          cur = got; last_txn = got; pc_hold = imem_addr;
          in_txn = 1'b1; wcnt = wait_tbl[txn % TBL]; req_len = 0;
        end else begin
          check({tag, " txn_stable"}, got, cur);
          check({tag, " pc_frozen"}, imem_addr, pc_hold);
        end
        req_len++;
        if (wcnt == 0) begin
          dmem_ready = 1'b1;
          dmem_rdata = rdata_tbl[txn % TBL];
          in_txn = 1'b0;
          len_q.push_back(req_len);
          txn++;
        end else begin
          dmem_ready = 1'b0;
          dmem_rdata = W'($urandom);
          wcnt--;
        end
      end else begin
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = W'($urandom);
      end
      @(negedge clk);
    end
    dmem_ready = 1'b0;
    check({tag, " done_cycle"}, done_cyc, 3 + m_retired + m_extra);
    check({tag, " retired"}, retired, m_retired);
    check({tag, " txn_total"}, txn, m_txn);
  endtask

  initial begin
    int   nreq;
    logic seen;
    int   br_trace [6];
    checks = 0;
    failures = 0;
    reset = 1'b0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    dmem_ready_x = 1'b1;
    dmem_rdata_x = '0;
    last_txn = '0;
    clear_rom();
    for (int i = 0; i < (1 << XD); i++) rom_x[i] = HALT;

    // reset with random instruction data
    for (int i = 0; i < 16; i++) rom[i] = 9'($urandom_range(0, 511));
    repeat (3) begin
      @(negedge clk);
      dmem_ready = 1'($urandom_range(0, 1));
      check("rst imem_addr", imem_addr, 0);
      check("rst dmem_req", dmem_req, 0);
      check("rst dmem_we", dmem_we, 0);
      check("rst dmem_addr", dmem_addr, 0);
      check("rst dmem_wdata", dmem_wdata, 0);
      check("rst done", done, 0);
      check("rst retired", retired, 0);
    end

    // arithmetic: LDI R1,3; LDI R2,-2; ADD R1,R2; LDI R3,0; ST R1,[R3]
    clear_rom(); clear_tables();
    rom[0] = enc(4, 1, 3); rom[1] = enc(4, 2, 6); rom[2] = enc(0, 1, 2);
    rom[3] = enc(4, 3, 0); rom[4] = enc(6, 1, 3);
    model_run();
    do_reset();
    run_prog("arith", 100);
    check("arith st", last_txn, {1'b1, 8'h00, 8'h01});

    // branch flush: taken BR Z to 6 squashes the instruction at 4
    clear_rom(); clear_tables();
    rom[0] = enc(4, 6, 3); rom[1] = enc(0, 6, 6); rom[2] = enc(1, 4, 4);
    rom[3] = enc(7, 1, 6); rom[4] = enc(4, 5, 1); rom[5] = enc(4, 5, 1);
    rom[6] = enc(6, 5, 0);
    model_run();
    do_reset();
    run_prog("branch", 100);
    check("branch st_data", last_txn[W-1:0], 8'h00);
    br_trace = '{0, 1, 2, 3, 4, 6};
    for (int i = 0; i < 6; i++)
      check("branch trace", (i < trace_q.size()) ? trace_q[i] : '1, br_trace[i]);

    // memory wait: LD R1,[R2] with R2=5, four not-ready cycles, then ST R1
    clear_rom(); clear_tables();
    rom[0] = enc(4, 2, 2); rom[1] = enc(4, 3, 3); rom[2] = enc(0, 2, 3);
    rom[3] = enc(5, 1, 2); rom[4] = enc(6, 1, 0);
    wait_tbl[0] = 4; rdata_tbl[0] = 8'hA5;
    model_run();
    do_reset();
    run_prog("memwait", 100);
    check("memwait req_len", (len_q.size() > 0) ? len_q[0] : 0, 5);
    check("memwait st_data", last_txn[W-1:0], 8'hA5);

    // halt at address 2, stores behind it must never issue
    clear_rom(); clear_tables();
    rom[0] = enc(4, 1, 1); rom[1] = enc(4, 2, 2); rom[2] = HALT;
    rom[3] = enc(6, 1, 0); rom[4] = enc(6, 2, 0);
    model_run();
    do_reset();
    run_prog("halt", 100);
    repeat (5) begin
      dmem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("halt done", done, 1);
      check("halt imem_addr", imem_addr, 3);
      check("halt dmem_req", dmem_req, 0);
      check("halt retired", retired, 2);
    end

    // reset while a load is stalled
    clear_rom(); clear_tables();
    rom[0] = enc(4, 2, 1); rom[1] = enc(5, 1, 2);
    do_reset();
    reset = 1'b1;
    dmem_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (dmem_req) seen = 1'b1;
    end
    check("stall req_seen", seen, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("stall_rst dmem_req", dmem_req, 0);
    check("stall_rst imem_addr", imem_addr, 0);
    check("stall_rst retired", retired, 0);
    check("stall_rst dmem_addr", dmem_addr, 0);
    clear_rom();
    rom[0] = enc(6, 1, 2);
    model_run();
    do_reset();
    run_prog("post_rst", 100);
    check("post_rst st", last_txn, {1'b1, 8'h00, 8'h00});

    // random programs
    for (int k = 0; k < 8; k++) begin
      do begin
        clear_rom();
        for (int i = 0; i < 24; i++) rom[i] = 9'($urandom_range(0, 511));
        for (int i = 0; i < TBL; i++) begin
          wait_tbl[i]  = $urandom_range(0, 3);
          rdata_tbl[i] = W'($urandom);
        end
        model_run();
      end while (!m_halted);
      do_reset();
      run_prog("rand", 3000);
    end

    // wide instance: arithmetic program with W=16
    for (int i = 0; i < (1 << XD); i++) rom_x[i] = HALT;
    rom_x[0] = enc(4, 1, 3); rom_x[1] = enc(4, 2, 6); rom_x[2] = enc(0, 1, 2);
    rom_x[3] = enc(4, 3, 0); rom_x[4] = enc(6, 1, 3);
    do_reset();
    reset = 1'b1;
    nreq = 0;
    for (int c = 1; c <= 20 && !done_x; c++) begin
      if (dmem_req_x) begin
        nreq++;
        check("x_arith we", dmem_we_x, 1);
        check("x_arith addr", dmem_addr_x, 0);
        check("x_arith wdata", dmem_wdata_x, 16'h0001);
      end
      @(negedge clk);
    end
    check("x_arith nreq", nreq, 1);
    check("x_arith done", done_x, 1);
    check("x_arith retired", retired_x, 5);

    // wide instance: PC wrap at 2^4 and retired saturation at 7
    for (int i = 0; i < (1 << XD); i++) rom_x[i] = enc(4, 0, 0);
    do_reset();
    reset = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      if (c == 5)  check("x_retired early", retired_x, 3);
      if (c == 18) check("x_pc_wrap", imem_addr_x, 1);
      if (c == 20) check("x_retired sat", retired_x, 7);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
